// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - I2C target: address match, register pointer, write/read byte streaming (option: I2C_GLITCH_FILTER_EN)
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR = 7'h77
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [3:0] state,
  output logic       busy,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ACK_ADDR  = 4'd2,
    ST_PTR       = 4'd3,
    ST_ACK_PTR   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_ACK_WR    = 4'd6,
    ST_RDATA     = 4'd7,
    ST_ACK_IN    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  state_t     cur_state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic       oe_nxt, busy_nxt, wr_en_nxt;
  logic [7:0] wr_addr_nxt, wr_data_nxt;
  logic       rw, rw_nxt;
  logic       nack, nack_nxt;

  // Synchronised bus lines; reset to the idle-high level so leaving reset makes no edge
  logic [1:0] scl_sync, sda_sync;
  logic       scl_c, sda_c;
  logic       scl_q, sda_q;

  // Two-flop synchronisers for the asynchronous bus inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  // Majority of the current synced sample and the two before it: a 1-clk pulse never
  // wins a vote, a real level change wins one clock after it appears
  logic [1:0] scl_hist, sda_hist;

  // History of the synchronised samples feeding the majority vote
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
    end
  end

  assign scl_c = (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
  assign sda_c = (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
`else
  assign scl_c = scl_sync[1];
  assign sda_c = sda_sync[1];
`endif

  // Previous conditioned levels for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_c;
      sda_q <= sda_c;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, byte_done;
  assign scl_rise  = scl_c & ~scl_q;
  assign scl_fall  = ~scl_c & scl_q;
  // SDA moving while SCL has been high for at least one sample is a bus condition, not data
  assign start_det = ~sda_c & sda_q & scl_c & scl_q;
  assign stop_det  = sda_c & ~sda_q & scl_c & scl_q;
  // The falling edge that ends the 8th bit of a byte
  assign byte_done = scl_fall && (bit_cnt == 4'd8);

  assign state   = cur_state;
  assign rd_addr = ptr;

  // State, datapath and output registers; reset releases SDA immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      ptr       <= 8'h00;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      rw        <= 1'b0;
      nack      <= 1'b0;
    end else begin
      cur_state <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      ptr       <= ptr_nxt;
      sda_oe    <= oe_nxt;
      busy      <= busy_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      rw        <= rw_nxt;
      nack      <= nack_nxt;
    end
  end

  // Next-state and output decode; STOP and START take priority over bit handling
  always_comb begin
    state_nxt   = cur_state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    ptr_nxt     = ptr;
    oe_nxt      = sda_oe;
    busy_nxt    = busy;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    rw_nxt      = rw;
    nack_nxt    = nack;

    if (stop_det) begin
      state_nxt   = ST_IDLE;
      oe_nxt      = 1'b0;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = 4'd0;
    end else if (start_det) begin
      state_nxt   = ST_ADDR;
      oe_nxt      = 1'b0;
      bit_cnt_nxt = 4'd0;
    end else begin
      case (cur_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shift_nxt   = {shift[6:0], sda_c};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (byte_done) begin
            if (cur_state == ST_ADDR) begin
              if (shift[7:1] == TARGET_ADDR) begin
                state_nxt = ST_ACK_ADDR;
                oe_nxt    = 1'b1;
                busy_nxt  = 1'b1;
                rw_nxt    = shift[0];
              end else begin
                state_nxt = ST_WAIT_STOP;
              end
            end else if (cur_state == ST_PTR) begin
              state_nxt = ST_ACK_PTR;
              ptr_nxt   = shift;
              oe_nxt    = 1'b1;
            end else begin
              state_nxt = ST_ACK_WR;
              oe_nxt    = 1'b1;
            end
          end
        end
        ST_ACK_ADDR: begin
          if (scl_fall) begin
            bit_cnt_nxt = 4'd0;
            if (rw) begin
              state_nxt = ST_RDATA;
              shift_nxt = rd_data;
              oe_nxt    = ~rd_data[7];
            end else begin
              state_nxt = ST_PTR;
              oe_nxt    = 1'b0;
            end
          end
        end
        ST_ACK_PTR: begin
          if (scl_fall) begin
            state_nxt   = ST_WDATA;
            oe_nxt      = 1'b0;
            bit_cnt_nxt = 4'd0;
          end
        end
        ST_ACK_WR: begin
          if (scl_fall) begin
            state_nxt   = ST_WDATA;
            oe_nxt      = 1'b0;
            bit_cnt_nxt = 4'd0;
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = ptr;
            wr_data_nxt = shift;
            ptr_nxt     = ptr + 8'd1;
          end
        end
        ST_RDATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (byte_done) begin
            // Advance the pointer as the byte completes so rd_data for the next
            // address has settled before the reload on the ACK clock's fall
            state_nxt = ST_ACK_IN;
            oe_nxt    = 1'b0;
            ptr_nxt   = ptr + 8'd1;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            oe_nxt    = ~shift[6];
            shift_nxt = {shift[6:0], 1'b0};
          end
        end
        ST_ACK_IN: begin
          if (scl_rise && bit_cnt == 4'd8) begin
            nack_nxt    = sda_c;
            bit_cnt_nxt = 4'd9;
          end else if (scl_fall && bit_cnt == 4'd9) begin
            bit_cnt_nxt = 4'd0;
            if (nack) begin
              state_nxt = ST_WAIT_STOP;
              oe_nxt    = 1'b0;
            end else begin
              state_nxt = ST_RDATA;
              shift_nxt = rd_data;
              oe_nxt    = ~rd_data[7];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// tb/tb_i2c_target_responder.sv - self-checking bench for i2c_target_responder
`timescale 1ns/1ps
module tb_i2c_target_responder;

  localparam int T = 1000;
  localparam int Q = 3 * T;
  localparam int H = 6 * T;
  localparam logic [6:0] TADDR = 7'h77;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_oe;
  logic [3:0] state;
  logic       busy, wr_en;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       sda_line;

  // Open-drain bus: either side can pull low
  assign sda_line = m_sda & ~sda_oe;

  // Register file behind the target: unwritten locations read as address ^ 0xFF
  logic [7:0] mem [256];
  bit         vld [256];
  assign rd_data = vld[rd_addr] ? mem[rd_addr] : (rd_addr ^ 8'hFF);

  i2c_target_responder #(.TARGET_ADDR(TADDR)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .state(state), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #(T/2) clk = ~clk;

  logic [15:0] wr_log [$];
  int          oe_cnt = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_log.push_back({wr_addr, wr_data});
      mem[wr_addr] <= wr_data;
      vld[wr_addr] <= 1'b1;
    end
    if (sda_oe) oe_cnt++;
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: pointer, expected write pulses, and remembered register contents
  logic [7:0]  ref_ptr = 8'h00;
  logic [15:0] exp_wr [$];
  logic [7:0]  ref_mem [256];
  bit          ref_vld [256];
  int          wr_idx = 0;
  logic [7:0]  dbuf [4];

  function automatic logic [7:0] exp_rd(input logic [7:0] p);
    return ref_vld[p] ? ref_mem[p] : (p ^ 8'hFF);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      m_sda = 1'b1; #Q; scl = 1'b1; #H;
    end else begin
      m_sda = 1'b1; #H;
    end
    m_sda = 1'b0; #H;
    scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q;
    scl = 1'b1; #H;
    m_sda = 1'b1; #H;
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; #Q;
    scl = 1'b1; #H;
    scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; #Q;
    scl = 1'b1; #Q;
    b = sda_line; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic bt;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(bt);
    ack = ~bt;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      d[i] = bt;
    end
    write_bit(~ack);
  endtask

  task automatic compare_writes(input string tag);
    logic [15:0] e;
    logic [31:0] got;
    check({tag, "_wr_count"}, wr_log.size(), wr_idx + exp_wr.size());
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      got = (wr_idx < wr_log.size()) ? {16'h0, wr_log[wr_idx]} : 32'hDEAD_BEEF;
      check({tag, "_wr_pair"}, got, {16'h0, e});
      wr_idx++;
    end
    wr_idx = wr_log.size();
  endtask

  task automatic write_txn(input string tag, input logic [7:0] p, input int n, input bit do_stop);
    logic ack;
    bus_start();
    write_byte({TADDR, 1'b0}, ack);
    check({tag, "_addr_ack"}, ack, 1);
    check({tag, "_busy_on"}, busy, 1);
    write_byte(p, ack);
    check({tag, "_ptr_ack"}, ack, 1);
    ref_ptr = p;
    for (int i = 0; i < n; i++) begin
      write_byte(dbuf[i], ack);
      check({tag, "_data_ack"}, ack, 1);
      exp_wr.push_back({ref_ptr, dbuf[i]});
      ref_mem[ref_ptr] = dbuf[i];
      ref_vld[ref_ptr] = 1'b1;
      ref_ptr = ref_ptr + 8'd1;
    end
    if (do_stop) begin
      bus_stop();
      #(4*T);
      check({tag, "_idle"}, state, 0);
      check({tag, "_busy_off"}, busy, 0);
      check({tag, "_ptr"}, rd_addr, ref_ptr);
      compare_writes(tag);
    end
  endtask

  task automatic read_txn(input string tag, input int n);
    logic ack;
    logic [7:0] b;
    bus_start();
    write_byte({TADDR, 1'b1}, ack);
    check({tag, "_raddr_ack"}, ack, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(b, i < n - 1);
      check({tag, "_rdata"}, b, exp_rd(ref_ptr));
      ref_ptr = ref_ptr + 8'd1;
    end
    check({tag, "_wait_stop"}, state, 9);
    bus_stop();
    #(4*T);
    check({tag, "_idle"}, state, 0);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_ptr"}, rd_addr, ref_ptr);
  endtask

  initial begin
    logic       ack, bt;
    logic [6:0] badr;
    int         oe0, wcnt, n, guard;
    logic [7:0] p;

    // Reset
    #(5*T);
    check("rst_oe", sda_oe, 0);
    check("rst_state", state, 0);
    rst = 1'b1;
    #(3*T);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_ptr", rd_addr, 0);
    check("rst_state_after", state, 0);

    // Directed write of two bytes at pointer 0x10
    dbuf[0] = 8'hA5; dbuf[1] = 8'h5A;
    write_txn("wr_basic", 8'h10, 2, 1'b1);

    // Pointer write, repeated START, two-byte read ACK/NACK
    write_txn("rd_ptr", 8'h20, 0, 1'b0);
    read_txn("rd_basic", 2);
    check("rd_final_ptr", rd_addr, 8'h22);

    // Foreign address: no ACK, ignored until STOP
    oe0 = oe_cnt;
    wcnt = wr_log.size();
    bus_start();
    write_byte(8'hA0, ack);
    check("nomatch_ack", ack, 0);
    check("nomatch_state", state, 9);
    write_byte(8'h33, ack);
    check("nomatch_data_ack", ack, 0);
    bus_stop();
    #(4*T);
    check("nomatch_idle", state, 0);
    check("nomatch_oe_never", oe_cnt, oe0);
    check("nomatch_no_wr", wr_log.size(), wcnt);

    // Pointer wrap at 0xFF
    dbuf[0] = 8'($urandom); dbuf[1] = 8'($urandom);
    write_txn("wrap", 8'hFF, 2, 1'b1);

    // STOP injected mid-byte during a read
    p = ref_ptr;
    bus_start();
    write_byte({TADDR, 1'b1}, ack);
    check("stopmid_ack", ack, 1);
    for (int i = 0; i < 3; i++) begin
      read_bit(bt);
      check("stopmid_bit", bt, exp_rd(p) >> (7 - i) & 8'h1);
    end
    bus_stop();
    guard = 0;
    while (state != 4'd0 && guard < 20) begin
      #T;
      guard++;
    end
    check("stopmid_timeout", guard < 20, 1);
    check("stopmid_oe", sda_oe, 0);
    check("stopmid_busy", busy, 0);
    check("stopmid_ptr", rd_addr, p);

    // One-clock SCL glitch during a data byte
    write_txn("glitch", 8'h30, 0, 1'b0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    m_sda = 1'b0; #Q;
    scl = 1'b1; #T;
    scl = 1'b0; #(5*T);
`ifdef I2C_GLITCH_FILTER_EN
    check("glitch_bits", dut.bit_cnt, 3);
`else
    check("glitch_bits", dut.bit_cnt, 4);
`endif
    bus_stop();
    #(4*T);
    check("glitch_idle", state, 0);
    compare_writes("glitch");

    // Random foreign addresses
    for (int k = 0; k < 3; k++) begin
      badr = 7'($urandom);
      if (badr == TADDR) badr = 7'h12;
      oe0 = oe_cnt;
      bus_start();
      write_byte({badr, 1'($urandom)}, ack);
      check("rnd_nomatch_ack", ack, 0);
      bus_stop();
      #(4*T);
      check("rnd_nomatch_oe", oe_cnt, oe0);
    end

    // Random write then read-back transactions
    for (int k = 0; k < 5; k++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
      write_txn("rnd_wr", p, n, 1'b1);
      write_txn("rnd_rp", p, 0, 1'b0);
      read_txn("rnd_rd", n + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
